ixc_beat_assemble_84: RTL



---
 rtl/ixc_beat_assemble_84.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ixc_beat_assemble_84.sv
`timescale 1ns/1ps
// ixc_beat_assemble_84
//
// Receive-side beat assembler. Rebuilds a WORD_W-bit word from a stream of
// BEAT_W-bit beats sent LSB-first. Beat k fills bits [k*BEAT_W +: BEAT_W].
// A word is complete when the sender flags in_last, or when the final beat
// slot (cnt == BEATS-1) is filled, whichever happens first. Completed words
// are presented on a registered valid/ready output together with a framing
// error flag. A saturating counter tracks how many errored words were loaded.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   beat present
//   in_ready   beat accepted when in_valid && in_ready (combinational)
//   in_data    beat payload, BEAT_W bits
//   in_last    sender marks the final beat of a word
//   out_valid  assembled word held
//   out_ready  consumer accepts the word when out_valid && out_ready
//   out_data   assembled word, WORD_W bits
//   out_err    framing error on the held word (qualified by out_valid)
//   err_cnt    saturating count of words loaded with out_err = 1

module ixc_beat_assemble_84 #(
  parameter int WORD_W = 84,
  parameter int BEAT_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam int BEATS = WORD_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  // A partial trailing beat has no defined meaning, so refuse to elaborate.
  generate
    if ((BEAT_W <= 0) || (WORD_W < BEAT_W) || ((WORD_W % BEAT_W) != 0)) begin : g_bad_width
      $error("ixc_beat_assemble_84: WORD_W must be a positive multiple of BEAT_W");
    end
  endgenerate

  // State registers. The final beat never passes through asm_q: it is merged
  // straight into the output word, so asm_q only ever holds lower slices.
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [WORD_W-2:0] asm_q,       asm_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q,  out_data_d;
  logic              out_err_q,   out_err_d;
  logic [7:0]        err_cnt_q,   err_cnt_d;

  // Combinational helpers
  logic              ready_c;
  logic              accept_c;
  logic              slot_last_c;
  logic              term_c;
  logic              frame_err_c;
  logic [WORD_W-1:0] merged_c;

  // Ready depends only on the output holding register, never on the beat
  // itself, so the upstream sender sees no combinational loop through us.
  assign ready_c  = !out_valid_q || out_ready;
  assign in_ready = ready_c;

  always_comb begin
    accept_c    = in_valid && ready_c;
    slot_last_c = (cnt_q == LAST_CNT);
    term_c      = slot_last_c || in_last;
    // Only a beat that both fills the final slot and carries in_last is a
    // clean word; an early in_last or a missing in_last are both errors.
    frame_err_c = !(slot_last_c && in_last);

    // Word as it would look if the current beat terminated it. asm_q is
    // cleared at every word boundary, so slices above cnt_q are zero.
    merged_c = {1'b0, asm_q};
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        merged_c[k*BEAT_W +: BEAT_W] = in_data;
      end
    end

    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;

    // Output handshake retires the held word; a terminating beat accepted
    // in the same cycle overrides this below and keeps out_valid high.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept_c) begin
      if (term_c) begin
        out_valid_d = 1'b1;
        out_data_d  = merged_c;
        out_err_d   = frame_err_c;
        if (frame_err_c && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        cnt_d = '0;
        asm_d = '0;
      end else begin
        // The last slot always terminates, so only lower slots land here.
        for (int k = 0; k < BEATS - 1; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            asm_d[k*BEAT_W +: BEAT_W] = in_data;
          end
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---- Register stage: assembly state and output holding register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
